// File: rtl/fft_sample_loader.sv
// FFT input stage: accepts one complex sample per handshake, writes it to the working RAM
// at its bit-reversed address, and pulses fft_start once a whole frame is in place.
module fft_sample_loader #(
  parameter int N_SAMPLES = 32,
  parameter int LOG2N     = 5,
  parameter int DATA_W    = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  load_start,
  input  logic                  load_abort,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_real,
  input  logic [DATA_W-1:0]     in_imag,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [LOG2N-1:0]      mem_addr,
  output logic [2*DATA_W-1:0]   mem_wdata,
  output logic                  load_busy,
  output logic [LOG2N:0]        sample_count,
  output logic                  fft_start
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, START} state_t;

  state_t                state_q;
  logic [LOG2N:0]        count_q;
  logic                  mem_we_q;
  logic [LOG2N-1:0]      mem_addr_q;
  logic [2*DATA_W-1:0]   mem_wdata_q;
  logic                  fft_start_q;

  logic [LOG2N:0]        count_d;
  logic [LOG2N-1:0]      mem_addr_d;
  logic [2*DATA_W-1:0]   mem_wdata_d;
  logic                  last_sample;

  // Bit reversal of the low count bits is pure wiring.
  for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
    assign mem_addr_d[gi] = count_q[LOG2N-1-gi];
  end

  assign count_d     = count_q + (LOG2N+1)'(1);
  assign mem_wdata_d = {in_real, in_imag};
  assign last_sample = (count_q == (LOG2N+1)'(N_SAMPLES-1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fft_start_q <= 1'b0;
    end else begin
      mem_we_q    <= 1'b0;
      fft_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_start) begin
            state_q <= LOAD;
            count_q <= '0;
          end
        end
        LOAD: begin
          // Abort wins over a simultaneous accept; that sample is dropped.
          if (load_abort) begin
            state_q <= IDLE;
            count_q <= '0;
          end else if (in_valid) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            count_q     <= count_d;
            if (last_sample) begin
              state_q <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (load_abort) begin
            state_q <= IDLE;
            count_q <= '0;
          end else begin
            state_q     <= START;
            fft_start_q <= 1'b1;
          end
        end
        START: begin
          state_q <= IDLE;
          count_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  assign in_ready     = (state_q == LOAD);
  assign load_busy    = (state_q != IDLE);
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign sample_count = count_q;
  assign fft_start    = fft_start_q;

endmodule
